// File: rtl/bf_mem_pkg.sv
// Shared constants and types for the Bellman-Ford working memories.
// Holds the default geometry, the "infinity" fill word and the fill-sequencer state type.
package bf_mem_pkg;

    localparam int BF_WIDTH  = 128;
    localparam int BF_ADDR_W = 13;
    localparam int BF_DEPTH  = 8192;

    localparam logic [BF_WIDTH-1:0] BF_INF = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/mem_init_seq.sv
// Fill sequencer: walks a pointer over every word once per InitStart and
// requests one INIT_VALUE write per cycle; pulses o_done when the sweep ends.
module mem_init_seq
    import bf_mem_pkg::*;
#(
    parameter int ADDR_W = BF_ADDR_W,
    parameter int DEPTH  = BF_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fill_we,
    output logic [ADDR_W-1:0] o_fill_addr
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    fill_state_e       r_state;
    fill_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // NOTE: defaults assigned first so every path drives every output and no
    // latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_FILL;
                    w_ptr_nxt   = '0;
                end
            end
            ST_FILL: begin
                if (r_ptr == LAST_PTR) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_busy      = (r_state == ST_FILL);
    assign o_done      = (r_state == ST_DONE);
    // A reset landing mid-sweep must not write the word the pointer sits on.
    assign o_fill_we   = o_busy && !reset;
    assign o_fill_addr = r_ptr;

endmodule

// File: rtl/sram_nr1w_init.sv
// N-read / 1-write working memory with optional registered, write-first reads
// and a built-in sequencer that fills every word with INIT_VALUE.
module sram_nr1w_init
    import bf_mem_pkg::*;
#(
    parameter int              WIDTH      = BF_WIDTH,
    parameter int              ADDR_W     = BF_ADDR_W,
    parameter int              DEPTH      = BF_DEPTH,
    parameter int              NUM_RD     = 2,
    parameter int              READ_REG   = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE = BF_INF[WIDTH-1:0]
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     WE,
    input  logic [ADDR_W-1:0]        WriteAddress,
    input  logic [WIDTH-1:0]         WriteBus,
    input  logic [NUM_RD*ADDR_W-1:0] ReadAddress,
    output logic [NUM_RD*WIDTH-1:0]  ReadBus,
    input  logic                     InitStart,
    output logic                     InitBusy,
    output logic                     InitDone,
    output logic                     WriteDropped
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              r_wr_dropped;

    logic              w_busy;
    logic              w_done;
    logic              w_fill_we;
    logic [ADDR_W-1:0] w_fill_addr;
    logic              w_user_ok;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [WIDTH-1:0]  w_wr_data;

    mem_init_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_init_seq (
        .clock       (clock),
        .reset       (reset),
        .i_start     (InitStart),
        .o_busy      (w_busy),
        .o_done      (w_done),
        .o_fill_we   (w_fill_we),
        .o_fill_addr (w_fill_addr)
    );

    // The fill owns the write port while busy, so the two sources never collide.
    assign w_user_ok = WE && !w_busy && ({1'b0, WriteAddress} < DEPTH_W);

    always_comb begin
        w_wr_en   = w_fill_we || w_user_ok;
        w_wr_addr = WriteAddress;
        w_wr_data = WriteBus;
        if (w_fill_we) begin
            w_wr_addr = w_fill_addr;
            w_wr_data = INIT_VALUE;
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; clearing it is
    // the fill sequencer's job.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr[IDX_W-1:0]] <= w_wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_dropped <= 1'b0;
        end else begin
            r_wr_dropped <= WE && !w_user_ok;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_rd_addr;
        logic              w_rd_ok;
        logic [WIDTH-1:0]  w_rd_word;

        assign w_rd_addr = ReadAddress[g*ADDR_W +: ADDR_W];
        assign w_rd_ok   = ({1'b0, w_rd_addr} < DEPTH_W);
        assign w_rd_word = w_rd_ok ? r_mem[w_rd_addr[IDX_W-1:0]] : '0;

        if (READ_REG != 0) begin : g_reg
            logic [WIDTH-1:0] r_rd_data;

            // Write-first: a same-edge write to this address wins over the stale word.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_rd_data <= '0;
                end else if (w_wr_en && (w_wr_addr == w_rd_addr)) begin
                    r_rd_data <= w_wr_data;
                end else begin
                    r_rd_data <= w_rd_word;
                end
            end

            assign ReadBus[g*WIDTH +: WIDTH] = r_rd_data;
        end else begin : g_comb
            assign ReadBus[g*WIDTH +: WIDTH] = w_rd_word;
        end
    end

    assign InitBusy     = w_busy;
    assign InitDone     = w_done;
    assign WriteDropped = r_wr_dropped;

endmodule

// File: tb/tb_sram_nr1w_init.sv
// Scoreboard bench: a registered 2-port instance and a combinational 4-port
// instance share all write/fill stimulus and are checked against an array model.
module tb_sram_nr1w_init;

    localparam int W  = 16;
    localparam int AW = 5;
    localparam int D  = 16;
    localparam int NR = 2;
    localparam int NC = 4;
    localparam logic [W-1:0] INF = 16'hFFFF;

    logic            clock = 1'b0;
    logic            reset;
    logic            WE;
    logic [AW-1:0]   WriteAddress;
    logic [W-1:0]    WriteBus;
    logic            InitStart;
    logic [NR*AW-1:0] ra_r;
    logic [NR*W-1:0]  rb_r;
    logic [NC*AW-1:0] ra_c;
    logic [NC*W-1:0]  rb_c;
    logic            busy_r, done_r, drop_r;
    logic            busy_c, done_c, drop_c;

    always #5 clock = ~clock;

    sram_nr1w_init #(
        .WIDTH(W), .ADDR_W(AW), .DEPTH(D), .NUM_RD(NR), .READ_REG(1), .INIT_VALUE(INF)
    ) u_reg (
        .clock(clock), .reset(reset), .WE(WE), .WriteAddress(WriteAddress),
        .WriteBus(WriteBus), .ReadAddress(ra_r), .ReadBus(rb_r),
        .InitStart(InitStart), .InitBusy(busy_r), .InitDone(done_r),
        .WriteDropped(drop_r)
    );

    sram_nr1w_init #(
        .WIDTH(W), .ADDR_W(AW), .DEPTH(D), .NUM_RD(NC), .READ_REG(0), .INIT_VALUE(INF)
    ) u_comb (
        .clock(clock), .reset(reset), .WE(WE), .WriteAddress(WriteAddress),
        .WriteBus(WriteBus), .ReadAddress(ra_c), .ReadBus(rb_c),
        .InitStart(InitStart), .InitBusy(busy_c), .InitDone(done_c),
        .WriteDropped(drop_c)
    );

    typedef struct packed {
        logic [NR-1:0][W-1:0] rd_r;
        logic [NC-1:0][W-1:0] rd_c;
        logic                 busy;
        logic                 done;
        logic                 drop;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference model: the array contents plus "sweep in progress / sweep just finished".
    logic [W-1:0] m_mem [D];
    bit           m_fill = 1'b0;
    int           m_pos  = 0;
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;

    function automatic logic [W-1:0] rd_model(input logic [AW-1:0] a);
        return (int'(a) < D) ? m_mem[int'(a)] : '0;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        if ($isunknown(exp)) return;
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_r();
        for (int i = 0; i < NR; i++) ra_r[i*AW +: AW] = AW'($urandom_range(0, 31));
    endtask

    task automatic rand_c();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 31));
        for (int i = 0; i < NC; i++) begin
            ra_c[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, 31));
        end
    endtask

    // Applies the coming edge to the model, queues the post-edge expectations, steps one clock.
    task automatic cycle();
        exp_t e;
        bit   user_ok;
        bit   drop;
        rand_c();
        drop = 1'b0;
        if (reset) begin
            m_fill = 1'b0;
            m_busy = 1'b0;
            m_done = 1'b0;
        end else begin
            user_ok = WE && !m_busy && (int'(WriteAddress) < D);
            drop    = WE && !user_ok;
            if (user_ok) m_mem[int'(WriteAddress)] = WriteBus;
            if (m_fill) begin
                m_mem[m_pos] = INF;
                m_pos++;
                if (m_pos == D) begin
                    m_fill = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
            end else if (InitStart) begin
                m_fill = 1'b1;
                m_pos  = 0;
            end
            m_busy = m_fill;
        end
        e.busy = m_busy;
        e.done = m_done;
        e.drop = drop;
        for (int i = 0; i < NR; i++) e.rd_r[i] = reset ? '0 : rd_model(ra_r[i*AW +: AW]);
        for (int i = 0; i < NC; i++) e.rd_c[i] = rd_model(ra_c[i*AW +: AW]);
        exp_q.push_back(e);
        @(posedge clock);
        #3;
    endtask

    task automatic preload(input logic [W-1:0] val);
        for (int a = 0; a < D; a++) begin
            WE = 1'b1;
            WriteAddress = AW'(a);
            WriteBus = val;
            rand_r();
            cycle();
        end
        WE = 1'b0;
    endtask

    task automatic readback();
        for (int a = 0; a < D; a++) begin
            ra_r[0 +: AW]  = AW'(a);
            ra_r[AW +: AW] = AW'(D - 1 - a);
            cycle();
        end
    endtask

    task automatic write1(input int a, input logic [W-1:0] d);
        WE = 1'b1;
        WriteAddress = AW'(a);
        WriteBus = d;
        cycle();
        WE = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NR; i++) check($sformatf("reg_rd%0d", i), rb_r[i*W +: W], e.rd_r[i]);
                for (int i = 0; i < NC; i++) check($sformatf("comb_rd%0d", i), rb_c[i*W +: W], e.rd_c[i]);
                check("busy", W'(busy_r), W'(e.busy));
                check("done", W'(done_r), W'(e.done));
                check("dropped", W'(drop_r), W'(e.drop));
                check("comb_busy", W'(busy_c), W'(e.busy));
                check("comb_done", W'(done_c), W'(e.done));
            end
        end
    end

    initial begin : driver
        reset = 1'b1;
        WE = 1'b0;
        WriteAddress = '0;
        WriteBus = '0;
        InitStart = 1'b0;
        ra_r = '0;
        ra_c = '0;
        #3;
        repeat (2) cycle();
        reset = 1'b0;

        preload(16'h0001);

        // Registered read of two fresh writes, then same-edge forwarding.
        write1(3, 16'h1234);
        write1(5, 16'hBEEF);
        ra_r[0 +: AW] = AW'(3);
        ra_r[AW +: AW] = AW'(5);
        cycle();
        ra_r[0 +: AW] = AW'(7);
        write1(7, 16'hAAAA);
        cycle();

        // Full fill with a repeated start and a rejected write while busy.
        InitStart = 1'b1;
        cycle();
        InitStart = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rand_r();
            if (i == 4) InitStart = 1'b1;
            if (i == 6) begin
                WE = 1'b1;
                WriteAddress = AW'(2);
                WriteBus = 16'h5555;
            end
            cycle();
            InitStart = 1'b0;
            WE = 1'b0;
        end
        readback();

        // Write accepted in the start cycle, later overwritten by the sweep.
        preload(16'h0001);
        ra_r[0 +: AW] = AW'(9);
        WE = 1'b1;
        WriteAddress = AW'(9);
        WriteBus = 16'h7777;
        InitStart = 1'b1;
        cycle();
        WE = 1'b0;
        InitStart = 1'b0;
        repeat (18) begin
            rand_r();
            cycle();
        end
        readback();

        // Reset after six fill writes.
        preload(16'h0001);
        InitStart = 1'b1;
        cycle();
        InitStart = 1'b0;
        repeat (6) begin
            rand_r();
            cycle();
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (3) cycle();
        readback();

        // Out-of-range write and reads.
        ra_r[0 +: AW] = AW'(20);
        ra_r[AW +: AW] = AW'(31);
        write1(20, 16'hDEAD);
        cycle();
        readback();

        repeat (400) begin
            reset     = ($urandom_range(0, 149) == 0);
            InitStart = ($urandom_range(0, 39) == 0);
            WE        = !reset && ($urandom_range(0, 1) == 1);
            WriteAddress = AW'($urandom_range(0, 31));
            WriteBus     = W'($urandom);
            rand_r();
            cycle();
        end
        reset = 1'b0;
        WE = 1'b0;
        InitStart = 1'b0;

        repeat (2) @(posedge clock);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
